// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding and note-table field layout.
package song_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_PLAY
    } state_t;

    localparam int DUR_MSB  = 15;
    localparam int DUR_LSB  = 8;
    localparam int NOTE_MSB = 6;
    localparam int NOTE_LSB = 0;

    localparam logic [7:0] END_MARKER = 8'h00;

endpackage

// File: rtl/beat_timer.sv
// Duration tick generator: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap cycle.
module beat_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Autonomous note-table player driving the synth key mask from RAM port B.
// Build option: define SONG_LOOP_EN to restart the table at base_addr after each natural end-of-song.
module song_sequencer
    import song_pkg::*;
#(
    parameter int          TICK_DIV = 50000,
    parameter logic [15:0] MAX_LEN  = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] base_addr,
    input  logic [15:0] mem_data,
    output logic [15:0] mem_addr,
    output logic [15:0] notes,
    output logic        playing,
    output logic        done
);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  dur_q, dur_d;
    logic [6:0]  notes_q, notes_d;
    logic        done_q, done_d;
`ifdef SONG_LOOP_EN
    logic [15:0] base_q, base_d;
`endif

    logic [7:0] word_dur;
    logic [6:0] word_mask;
    logic       unused_word_bit;
    logic       tick;

    assign word_dur        = mem_data[DUR_MSB:DUR_LSB];
    assign word_mask       = mem_data[NOTE_MSB:NOTE_LSB];
    assign unused_word_bit = mem_data[7];

    beat_timer #(
        .TICK_DIV(TICK_DIV)
    ) u_beat_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_q != ST_PLAY),
        .enable(state_q == ST_PLAY),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        dur_d   = dur_q;
        notes_d = notes_q;
        done_d  = 1'b0;
`ifdef SONG_LOOP_EN
        base_d  = base_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    state_d = ST_FETCH;
`ifdef SONG_LOOP_EN
                    base_d  = base_addr;
`endif
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_LOAD;
            ST_LOAD: begin
                if (word_dur != END_MARKER && count_q < MAX_LEN) begin
                    notes_d = word_mask;
                    dur_d   = word_dur;
                    addr_d  = addr_q + 16'd1;
                    count_d = count_q + 16'd1;
                    state_d = ST_PLAY;
                end else begin
                    done_d = 1'b1;
`ifdef SONG_LOOP_EN
                    // An empty table must still terminate, otherwise the loop would spin forever.
                    if (count_q != 16'd0) begin
                        addr_d  = base_q;
                        count_d = '0;
                        state_d = ST_FETCH;
                    end else begin
                        notes_d = '0;
                        state_d = ST_IDLE;
                    end
`else
                    notes_d = '0;
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    dur_d = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and end-of-song; the address is left where it was.
        if (stop) begin
            state_d = ST_IDLE;
            addr_d  = addr_q;
            count_d = count_q;
            notes_d = '0;
            done_d  = 1'b0;
`ifdef SONG_LOOP_EN
            base_d  = base_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            dur_q   <= '0;
            notes_q <= '0;
            done_q  <= 1'b0;
`ifdef SONG_LOOP_EN
            base_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            dur_q   <= dur_d;
            notes_q <= notes_d;
            done_q  <= done_d;
`ifdef SONG_LOOP_EN
            base_q  <= base_d;
`endif
        end
    end

    assign mem_addr = addr_q;
    assign notes    = {9'b0, notes_q};
    assign playing  = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed songs plus random tables against a timeline model.
module tb_song_sequencer;

    localparam int          T    = 4;
    localparam logic [15:0] MAXL = 16'd3;
`ifdef SONG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] notes;
        logic        playing;
        logic        done;
    } cyc_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic [15:0] base_addr = 16'h0;
    logic [15:0] mem_data, mem_addr, notes;
    logic        playing, done;

    logic [15:0] ram [0:65535];
    logic [15:0] ram_addr_q = 16'h0;

    int vectors    = 0;
    int miscompares = 0;
    cyc_t exp_q[$];

    song_sequencer #(.TICK_DIV(T), .MAX_LEN(MAXL)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .base_addr(base_addr),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .notes    (notes),
        .playing  (playing),
        .done     (done)
    );

    always #5 clock = ~clock;

    // RAM port B: registered address, unregistered data
    always @(posedge clock) ram_addr_q <= mem_addr;
    assign mem_data = ram[ram_addr_q];

    function automatic cyc_t mk(input logic [15:0] a, input logic [15:0] n, input logic p, input logic d);
        cyc_t c;
        c.addr = a; c.notes = n; c.playing = p; c.done = d;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input cyc_t e);
        chk({tag, ".mem_addr"}, mem_addr, e.addr);
        chk({tag, ".notes"}, notes, e.notes);
        chk({tag, ".playing"}, {15'b0, playing}, {15'b0, e.playing});
        chk({tag, ".done"}, {15'b0, done}, {15'b0, e.done});
    endtask

    // Expected per-cycle outputs after each clock edge, starting with the edge that accepts start.
    task automatic build_trace(input logic [15:0] base, input int ncyc);
        logic [15:0] addr = base;
        logic [15:0] nt = 16'h0;
        logic [15:0] w;
        int          count = 0;
        bit          ended = 1'b0;
        bit          pend_done = 1'b0;
        exp_q.delete();
        while (exp_q.size() < ncyc) begin
            if (ended) begin
                exp_q.push_back(mk(addr, 16'h0, 1'b0, 1'b0));
            end else begin
                for (int k = 0; k < 3; k++) begin
                    exp_q.push_back(mk(addr, nt, 1'b1, pend_done && k == 0));
                end
                pend_done = 1'b0;
                w = ram[addr];
                if (w[15:8] == 8'h00 || count == int'(MAXL)) begin
                    if (LOOP && count > 0) begin
                        addr = base;
                        count = 0;
                        pend_done = 1'b1;
                    end else begin
                        nt = 16'h0;
                        exp_q.push_back(mk(addr, nt, 1'b0, 1'b1));
                        ended = 1'b1;
                    end
                end else begin
                    nt = {9'b0, w[6:0]};
                    addr = addr + 16'd1;
                    count++;
                    repeat (int'(w[15:8]) * T) exp_q.push_back(mk(addr, nt, 1'b1, 1'b0));
                end
            end
        end
    endtask

    task automatic run(input string name, input logic [15:0] base, input int ncyc,
                       input int stop_at, input int restart_at, input logic [15:0] restart_base);
        bit          stopped = 1'b0;
        logic [15:0] held = 16'h0;
        build_trace(base, ncyc);
        @(negedge clock);
        start = 1'b1;
        base_addr = base;
        @(negedge clock);
        start = 1'b0;
        base_addr = 16'($urandom);
        for (int i = 0; i < ncyc; i++) begin
            if (stopped) chk_cyc($sformatf("%s[%0d]", name, i), mk(held, 16'h0, 1'b0, 1'b0));
            else         chk_cyc($sformatf("%s[%0d]", name, i), exp_q[i]);
            stop = 1'b0;
            start = 1'b0;
            if (i == stop_at) begin
                stop = 1'b1;
                stopped = 1'b1;
                held = exp_q[i].addr;
            end
            if (i == restart_at) begin
                start = 1'b1;
                base_addr = restart_base;
            end
            @(negedge clock);
        end
        start = 1'b0;
        stop = 1'b1;
        @(negedge clock);
        stop = 1'b0;
    endtask

    task automatic write_song(input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            ram[base + 16'(k)] = {8'($urandom_range(1, 3)), 8'($urandom_range(0, 255))};
        end
        ram[base + 16'(n)] = {8'h00, 8'($urandom_range(0, 255))};
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 16'h0000;
        ram[16'h0010] = 16'h0201;
        ram[16'h0011] = 16'h0140;
        ram[16'h0012] = 16'h0000;
        ram[16'h0020] = 16'h0000;
        ram[16'hFFFF] = 16'h0104;
        ram[16'h0030] = 16'h0101;
        ram[16'h0031] = 16'h0182;
        ram[16'h0032] = 16'h0104;
        ram[16'h0033] = 16'h0108;
        ram[16'h0034] = 16'h0000;

        repeat (3) @(negedge clock);
        chk_cyc("reset", mk(16'h0, 16'h0, 1'b0, 1'b0));
        reset = 1'b1;
        @(negedge clock);
        chk_cyc("post_reset", mk(16'h0, 16'h0, 1'b0, 1'b0));

        run("basic", 16'h0010, 30, -1, -1, 16'h0);
        run("stop_mid", 16'h0010, 14, 7, -1, 16'h0);
        run("empty", 16'h0020, 8, -1, -1, 16'h0);
        run("wrap", 16'hFFFF, 14, -1, -1, 16'h0);
        run("max_len", 16'h0030, 30, -1, -1, 16'h0);
        run("restart_ignored", 16'h0010, 30, -1, 5, 16'h0020);

        @(negedge clock);
        start = 1'b1;
        stop = 1'b1;
        base_addr = 16'h0010;
        @(negedge clock);
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("start_stop[%0d].playing", i), {15'b0, playing}, 16'h0);
            chk($sformatf("start_stop[%0d].notes", i), notes, 16'h0);
            chk($sformatf("start_stop[%0d].done", i), {15'b0, done}, 16'h0);
            @(negedge clock);
        end

        for (int r = 0; r < 8; r++) begin
            logic [15:0] b;
            int          n;
            int          sa;
            b = 16'h0100 + 16'(r * 16'h40);
            n = $urandom_range(0, 5);
            write_song(b, n);
            sa = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 60) : -1;
            run($sformatf("rand%0d", r), b, 100, sa, -1, 16'h0);
        end

        build_trace(16'h0010, 10);
        @(negedge clock);
        start = 1'b1;
        base_addr = 16'h0010;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk_cyc("pre_async_reset", exp_q[6]);
        reset = 1'b0;
        #1;
        chk_cyc("async_reset", mk(16'h0, 16'h0, 1'b0, 1'b0));
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_cyc("after_async_reset", mk(16'h0, 16'h0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
